// File: rtl/mm2_load_resp.sv
// mm2_load_resp
//   Memory-response end of the MM1/MM2 data-SRAM protocol. Accepts in-order
//   data_ok/rdata responses, discards responses owed to flushed
//   instructions, holds a response while writeback stalls, and aligns and
//   extends load data into the writeback result. Also generates the MM2
//   ready_go / allowin handshake.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 kill MM1/MM2 instructions this cycle
//   in_valid .. in_pc     MM2 instruction (memory flags, size, sign, addr[1:0],
//                         ALU result, writeback tags)
//   mm1_req_pending       MM1 holds an accepted request not yet in MM2
//   data_sram_data_ok/_rdata  response handshake and data
//   ws_allowin            writeback can accept
//   mm2_allowin           wen of the MM1->MM2 register
//   mm2_ready_go          MM2 instruction has its result
//   wb_valid, wb_data, wb_reg_d, wb_wen, wb_pc  writeback payload
module mm2_load_resp #(
    parameter int unsigned CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_mm_req,
    input  logic        in_mm_re,
    input  logic [1:0]  in_access_sz,
    input  logic        in_unsigned,
    input  logic [1:0]  in_addr_l,
    input  logic [31:0] in_exe_out,
    input  logic [4:0]  in_reg_d,
    input  logic        in_reg_d_wen,
    input  logic [31:0] in_pc,
    input  logic        mm1_req_pending,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    output logic        mm2_allowin,
    output logic        mm2_ready_go,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg_d,
    output logic        wb_wen,
    output logic [31:0] wb_pc
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } st_e;

    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] DCNT_MAX = {2'b00, {CNT_W{1'b1}}};

    st_e              st_q;
    logic [31:0]      buf_q;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] dcnt_d;

    logic             take;
    logic             drop;
    logic             orphan;
    logic             capture;
    logic             dcnt_ovf;
    logic [SUM_W-1:0] dcnt_sum;
    logic [31:0]      rd;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      load_v;

    // Responses are owned by the current instruction only once every
    // orphaned response has drained.
    assign take    = data_sram_data_ok && (dcnt_q == '0);
    assign drop    = data_sram_data_ok && (dcnt_q != '0);
    assign orphan  = in_valid && in_mm_req && (st_q == ST_EMPTY) && !take;
    assign capture = in_valid && in_mm_req && take && !ws_allowin && !flush;

    always_comb begin
        mm2_ready_go = 1'b0;
        if (!in_mm_req)
            mm2_ready_go = 1'b1;
        else if (st_q == ST_FULL)
            mm2_ready_go = 1'b1;
        else if (take && in_valid)
            mm2_ready_go = 1'b1;
    end

    assign mm2_allowin = !in_valid || (mm2_ready_go && ws_allowin);
    assign wb_valid    = rst_n && in_valid && mm2_ready_go && !flush;
    assign wb_wen      = in_reg_d_wen && wb_valid;
    assign wb_reg_d    = in_reg_d;
    assign wb_pc       = in_pc;

    assign rd = (st_q == ST_FULL) ? buf_q : data_sram_rdata;

    always_comb begin
        byte_v = '0;
        case (in_addr_l)
            2'd0: byte_v = rd[7:0];
            2'd1: byte_v = rd[15:8];
            2'd2: byte_v = rd[23:16];
            2'd3: byte_v = rd[31:24];
        endcase
        // addr_l[0] is ignored for halves: misalignment traps upstream.
        half_v = in_addr_l[1] ? rd[31:16] : rd[15:0];
        case (in_access_sz)
            2'b00:   load_v = in_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_v = in_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: load_v = rd;
        endcase
    end

    assign wb_data = in_mm_re ? load_v : in_exe_out;

    // Extra headroom bits make overflow detectable; underflow cannot occur
    // because a drop only happens with a nonzero count.
    always_comb begin
        dcnt_sum = {2'b00, dcnt_q};
        if (drop)
            dcnt_sum = dcnt_sum - SUM_W'(1);
        if (flush)
            dcnt_sum = dcnt_sum + SUM_W'(orphan) + SUM_W'(mm1_req_pending);
        dcnt_ovf = (dcnt_sum > DCNT_MAX);
        dcnt_d   = dcnt_ovf ? '1 : dcnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= ST_EMPTY;
            buf_q  <= '0;
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
            case (st_q)
                ST_EMPTY: begin
                    if (capture) begin
                        st_q  <= ST_FULL;
                        buf_q <= data_sram_rdata;
                    end
                end
                ST_FULL: begin
                    if (flush || ws_allowin)
                        st_q <= ST_EMPTY;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(take && !in_valid))
                else $error("mm2_load_resp: response taken with no MM2 instruction");
            assert (!dcnt_ovf)
                else $error("mm2_load_resp: discard counter overflow");
        end
    end
`endif

endmodule

// File: tb/tb_mm2_load_resp.sv
// Directed bench for mm2_load_resp: inputs driven 1 time unit after posedge,
// outputs sampled on negedge.
module tb_mm2_load_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid, in_mm_req, in_mm_re, in_unsigned, in_reg_d_wen;
    logic [1:0]  in_access_sz, in_addr_l;
    logic [31:0] in_exe_out, in_pc;
    logic [4:0]  in_reg_d;
    logic        mm1_req_pending, data_sram_data_ok, ws_allowin;
    logic [31:0] data_sram_rdata;
    logic        mm2_allowin, mm2_ready_go, wb_valid, wb_wen;
    logic [31:0] wb_data, wb_pc;
    logic [4:0]  wb_reg_d;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mm2_load_resp #(.CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_mm_req(in_mm_req), .in_mm_re(in_mm_re),
        .in_access_sz(in_access_sz), .in_unsigned(in_unsigned),
        .in_addr_l(in_addr_l), .in_exe_out(in_exe_out),
        .in_reg_d(in_reg_d), .in_reg_d_wen(in_reg_d_wen), .in_pc(in_pc),
        .mm1_req_pending(mm1_req_pending),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ws_allowin(ws_allowin),
        .mm2_allowin(mm2_allowin), .mm2_ready_go(mm2_ready_go),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg_d(wb_reg_d),
        .wb_wen(wb_wen), .wb_pc(wb_pc)
    );

    // Instruction in MM2: valid, mm_req, mm_re, size, unsigned, addr_l, exe_out.
    task automatic instr(input logic v, input logic req, input logic re,
                         input logic [1:0] sz, input logic uns,
                         input logic [1:0] al, input logic [31:0] exe);
        in_valid = v; in_mm_req = req; in_mm_re = re; in_access_sz = sz;
        in_unsigned = uns; in_addr_l = al; in_exe_out = exe;
    endtask

    // Environment: data_ok, rdata, ws_allowin, flush, mm1_req_pending.
    task automatic env(input logic dok, input logic [31:0] rdat,
                       input logic wsa, input logic fl, input logic pend);
        data_sram_data_ok = dok; data_sram_rdata = rdat; ws_allowin = wsa;
        flush = fl; mm1_req_pending = pend;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        instr(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 32'h0);
        env(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_reg_d = 5'd7; in_reg_d_wen = 1'b1; in_pc = 32'h1c00_0040;
        instr(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 32'h1111);
        env(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        sample();
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        checks++;
        if (wb_wen !== 1'b0) begin errors++; $display("FAIL reset_wb_wen: got %b want 0", wb_wen); end
        tick();
        rst_n = 1'b1;
        // Load waiting on an empty buffer must not be ready after reset.
        instr(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h0);
        sample();
        checks++;
        if (mm2_ready_go !== 1'b0) begin errors++; $display("FAIL reset_empty_ready: got %b want 0", mm2_ready_go); end
        // Deliver the response so the bench starts from a clean slate.
        tick();
        env(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    task automatic test_lw();
        instr(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'hdead_0000);
        env(1'b1, 32'h8bad_f00d, 1'b1, 1'b0, 1'b0);
        sample();
        checks++;
        if (wb_valid !== 1'b1) begin errors++; $display("FAIL lw_valid: got %b want 1", wb_valid); end
        checks++;
        if (wb_data !== 32'h8bad_f00d) begin errors++; $display("FAIL lw_data: got %h want 8badf00d", wb_data); end
        checks++;
        if (mm2_allowin !== 1'b1) begin errors++; $display("FAIL lw_allowin: got %b want 1", mm2_allowin); end
        checks++;
        if (wb_wen !== 1'b1 || wb_reg_d !== 5'd7 || wb_pc !== 32'h1c00_0040) begin
            errors++; $display("FAIL lw_tags: got wen=%b rd=%0d pc=%h want 1/7/1c000040", wb_wen, wb_reg_d, wb_pc);
        end
        tick();
        idle();
    endtask

    task automatic test_extend();
        logic [1:0]  sz  [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        uns [8] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
        logic [1:0]  al  [8] = '{2'd3,  2'd3,  2'd2,  2'd2,  2'd1,  2'd0,  2'd3,  2'd0};
        logic [31:0] dat [8] = '{32'h8012_3456, 32'h8012_3456, 32'h8001_1234, 32'h8001_1234,
                                 32'h1234_5678, 32'h8001_1234, 32'h8001_1234, 32'h0000_00ff};
        logic [31:0] exp [8] = '{32'hffff_ff80, 32'h0000_0080, 32'hffff_8001, 32'h0000_8001,
                                 32'h0000_0056, 32'h0000_1234, 32'hffff_8001, 32'hffff_ffff};
        for (int i = 0; i < 8; i++) begin
            instr(1'b1, 1'b1, 1'b1, sz[i], uns[i], al[i], 32'h0);
            env(1'b1, dat[i], 1'b1, 1'b0, 1'b0);
            sample();
            checks++;
            if (wb_data !== exp[i] || wb_valid !== 1'b1) begin
                errors++; $display("FAIL extend_%0d: got %h valid=%b want %h valid=1", i, wb_data, wb_valid, exp[i]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_stall();
        instr(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h0);
        env(1'b1, 32'ha5a5_0001, 1'b0, 1'b0, 1'b0);
        sample();
        checks++;
        if (mm2_allowin !== 1'b0 || mm2_ready_go !== 1'b1) begin
            errors++; $display("FAIL stall_cap: got allowin=%b ready=%b want 0/1", mm2_allowin, mm2_ready_go);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            env(1'b0, 32'hdead_beef, 1'b0, 1'b0, 1'b0);
            sample();
            checks++;
            if (wb_data !== 32'ha5a5_0001 || mm2_ready_go !== 1'b1 || mm2_allowin !== 1'b0) begin
                errors++; $display("FAIL stall_hold_%0d: got data=%h ready=%b allowin=%b want a5a50001/1/0",
                                   i, wb_data, mm2_ready_go, mm2_allowin);
            end
            tick();
        end
        env(1'b0, 32'hdead_beef, 1'b1, 1'b0, 1'b0);
        sample();
        checks++;
        if (wb_data !== 32'ha5a5_0001 || mm2_allowin !== 1'b1) begin
            errors++; $display("FAIL stall_leave: got data=%h allowin=%b want a5a50001/1", wb_data, mm2_allowin);
        end
        tick();
        // Next load with no response yet: buffer must be empty again.
        env(1'b0, 32'hdead_beef, 1'b1, 1'b0, 1'b0);
        sample();
        checks++;
        if (mm2_ready_go !== 1'b0 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL stall_empty: got ready=%b valid=%b want 0/0", mm2_ready_go, wb_valid);
        end
        tick();
        env(1'b1, 32'h0000_0042, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    task automatic test_flush_pending();
        instr(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h0);
        env(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        sample();
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL flushp_kill: got %b want 0", wb_valid); end
        tick();
        // New load in MM2 while the two orphaned responses drain.
        for (int i = 0; i < 2; i++) begin
            instr(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h0);
            env(1'b1, 32'h0000_0111 * (i + 1), 1'b1, 1'b0, 1'b0);
            sample();
            checks++;
            if (wb_valid !== 1'b0 || mm2_ready_go !== 1'b0) begin
                errors++; $display("FAIL flushp_drop_%0d: got valid=%b ready=%b want 0/0", i, wb_valid, mm2_ready_go);
            end
            tick();
        end
        env(1'b1, 32'h0000_0333, 1'b1, 1'b0, 1'b0);
        sample();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h0000_0333) begin
            errors++; $display("FAIL flushp_take: got valid=%b data=%h want 1/00000333", wb_valid, wb_data);
        end
        tick();
        idle();
    endtask

    task automatic test_flush_same_cycle();
        instr(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h0);
        env(1'b1, 32'hcafe_cafe, 1'b0, 1'b1, 1'b0);
        sample();
        checks++;
        if (wb_valid !== 1'b0 || wb_wen !== 1'b0) begin
            errors++; $display("FAIL flushs_kill: got valid=%b wen=%b want 0/0", wb_valid, wb_wen);
        end
        tick();
        env(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        sample();
        checks++;
        if (mm2_ready_go !== 1'b0) begin errors++; $display("FAIL flushs_empty: got %b want 0", mm2_ready_go); end
        tick();
        env(1'b1, 32'h5555_aaaa, 1'b1, 1'b0, 1'b0);
        sample();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h5555_aaaa) begin
            errors++; $display("FAIL flushs_next: got valid=%b data=%h want 1/5555aaaa", wb_valid, wb_data);
        end
        tick();
        idle();
    endtask

    task automatic test_nonmem();
        instr(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 32'h0000_1234);
        env(1'b0, 32'hffff_ffff, 1'b1, 1'b0, 1'b0);
        sample();
        checks++;
        if (mm2_ready_go !== 1'b1 || wb_valid !== 1'b1 || wb_data !== 32'h0000_1234) begin
            errors++; $display("FAIL nonmem: got ready=%b valid=%b data=%h want 1/1/00001234", mm2_ready_go, wb_valid, wb_data);
        end
        in_reg_d_wen = 1'b0;
        sample();
        checks++;
        if (wb_wen !== 1'b0) begin errors++; $display("FAIL nonmem_nowen: got %b want 0", wb_wen); end
        in_reg_d_wen = 1'b1;
        tick();
        // Store: waits for its response, writes back exe_out.
        instr(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 32'h0000_abcd);
        env(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        sample();
        checks++;
        if (mm2_ready_go !== 1'b0 || mm2_allowin !== 1'b0) begin
            errors++; $display("FAIL store_wait: got ready=%b allowin=%b want 0/0", mm2_ready_go, mm2_allowin);
        end
        tick();
        env(1'b1, 32'h9999_9999, 1'b1, 1'b0, 1'b0);
        sample();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h0000_abcd) begin
            errors++; $display("FAIL store_done: got valid=%b data=%h want 1/0000abcd", wb_valid, wb_data);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_stall();
        instr(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h0);
        env(1'b1, 32'h1357_9bdf, 1'b0, 1'b0, 1'b0);
        tick();
        env(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        sample();
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", wb_valid); end
        tick();
        rst_n = 1'b1;
        sample();
        checks++;
        if (mm2_ready_go !== 1'b0) begin errors++; $display("FAIL rstmid_full: got %b want 0", mm2_ready_go); end
        tick();
        env(1'b1, 32'h0000_0077, 1'b1, 1'b0, 1'b0);
        sample();
        checks++;
        if (wb_data !== 32'h0000_0077) begin errors++; $display("FAIL rstmid_data: got %h want 00000077", wb_data); end
        tick();
        // Build a nonzero discard count, then reset it away.
        env(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        instr(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h0);
        env(1'b1, 32'h0000_0099, 1'b1, 1'b0, 1'b0);
        sample();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h0000_0099) begin
            errors++; $display("FAIL rstmid_dcnt: got valid=%b data=%h want 1/00000099", wb_valid, wb_data);
        end
        tick();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_lw();
        test_extend();
        test_stall();
        test_flush_pending();
        test_flush_same_cycle();
        test_nonmem();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
